// File: rtl/sm_acc_disp.sv
// Sign-magnitude accumulator with saturating overflow and a 4-digit multiplexed 7-segment driver.
// Latency: acc/ovf update 1 cycle after a strobe; display outputs lag the refresh counter and acc by 1 cycle.
// Backpressure: none; every strobe is accepted, and clr > load > add when strobes coincide.
module sm_acc_disp #(
  parameter int N     = 8,
  parameter int REF_W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         add_stb,
  input  logic         load_stb,
  input  logic         clr_stb,
  output logic [N-1:0] acc,
  output logic         ovf,
  output logic         zero,
  output logic [3:0]   an,
  output logic [7:0]   sseg
);

  localparam int M = N - 1;  // magnitude width
  localparam logic [REF_W-1:0] REF_ONE = {{(REF_W-1){1'b0}}, 1'b1};

  logic [N-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [REF_W-1:0] ref_q;
  logic [3:0]       an_q, an_d;
  logic [7:0]       sseg_q, sseg_d;

  logic           a_sign, d_sign, res_sign, ovf_add;
  logic [M-1:0]   a_mag, d_mag, res_mag, ld_mag;
  logic [N-1:0]   sum;

  logic [1:0]     digit;
  logic [11:0]    mag_ext;
  logic [3:0]     nib;

  // Hex digit to abcdefg pattern (a is bit 6, g is bit 0).
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  // Sign-magnitude add of acc and din, with saturation on magnitude carry-out.
  always_comb begin
    a_sign   = acc_q[N-1];
    a_mag    = acc_q[M-1:0];
    d_sign   = din[N-1];
    d_mag    = din[M-1:0];
    sum      = {1'b0, a_mag} + {1'b0, d_mag};
    res_sign = a_sign;
    res_mag  = a_mag;
    ovf_add  = 1'b0;
    if (a_sign == d_sign) begin
      if (sum[N-1]) begin
        res_mag = '1;
        ovf_add = 1'b1;
      end else begin
        res_mag = sum[M-1:0];
      end
    end else if (a_mag >= d_mag) begin
      res_sign = a_sign;
      res_mag  = a_mag - d_mag;
    end else begin
      res_sign = d_sign;
      res_mag  = d_mag - a_mag;
    end
  end

  // Command select with priority clr > load > add; any zero magnitude is stored as +0.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    ld_mag = din[M-1:0];
    if (clr_stb) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (load_stb) begin
      acc_d = (ld_mag == '0) ? '0 : din;
      ovf_d = 1'b0;
    end else if (add_stb) begin
      acc_d = (res_mag == '0) ? '0 : {res_sign, res_mag};
      ovf_d = ovf_q | ovf_add;
    end
  end

  // Display pattern for the digit selected by the top two refresh-counter bits.
  always_comb begin
    digit   = ref_q[REF_W-1:REF_W-2];
    mag_ext = '0;
    mag_ext[M-1:0] = acc_q[M-1:0];
    nib     = mag_ext[4*digit[1:0] +: 4];
    an_d    = 4'b0001 << digit;
    sseg_d  = {1'b0, hex7(nib)};
    case (digit)
      2'd0: sseg_d[7] = ovf_q;
      2'd1: if (M <= 4) sseg_d = 8'h00;
      2'd2: if (M <= 8) sseg_d = 8'h00;
      default: sseg_d = acc_q[N-1] ? 8'h01 : 8'h00;
    endcase
  end

  // Accumulator, sticky overflow, refresh counter and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      ref_q  <= '0;
      an_q   <= 4'b0000;
      sseg_q <= 8'h00;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      ref_q  <= ref_q + REF_ONE;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign acc  = acc_q;
  assign ovf  = ovf_q;
  assign zero = (acc_q[M-1:0] == '0);
  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_sm_acc_disp.sv
module tb_sm_acc_disp;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       add_stb, load_stb, clr_stb;
  logic [7:0] acc;
  logic       ovf, zero;
  logic [3:0] an;
  logic [7:0] sseg;

  int n_tests = 0;
  int n_fail  = 0;

  sm_acc_disp #(.N(8), .REF_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .add_stb  (add_stb),
    .load_stb (load_stb),
    .clr_stb  (clr_stb),
    .acc      (acc),
    .ovf      (ovf),
    .zero     (zero),
    .an       (an),
    .sseg     (sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive strobes for one clock edge; returns at the following negedge.
  task automatic op(input logic c, input logic l, input logic a, input logic [7:0] d);
    @(negedge clk);
    din = d; clr_stb = c; load_stb = l; add_stb = a;
    @(negedge clk);
    clr_stb = 1'b0; load_stb = 1'b0; add_stb = 1'b0;
  endtask

  // Wait (bounded) until an equals v; the final compare records a timeout.
  task automatic wait_an(input logic [3:0] v, input string tag);
    int cyc = 0;
    while (an !== v && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, {28'b0, an}, {28'b0, v});
  endtask

  function automatic logic [7:0] scan_sseg(input int d);
    case (d)
      0: scan_sseg = 8'hF7;  // dp + 'A'
      1: scan_sseg = 8'h30;  // '1'
      2: scan_sseg = 8'h00;  // blank
      default: scan_sseg = 8'h01;  // minus
    endcase
  endfunction

  initial begin
    reset = 1'b0; din = 8'h00;
    add_stb = 1'b0; load_stb = 1'b0; clr_stb = 1'b0;

    // 1. reset state and first scan digit
    repeat (2) @(negedge clk);
    check("rst_acc",  {24'b0, acc}, 32'h00);
    check("rst_ovf",  {31'b0, ovf}, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h1);
    check("rst_an",   {28'b0, an}, 32'h0);
    check("rst_sseg", {24'b0, sseg}, 32'h00);
    reset = 1'b1;
    @(negedge clk);
    check("first_an",   {28'b0, an}, 32'h1);
    check("first_sseg", {24'b0, sseg}, 32'h7E);

    // 2. mixed-sign adds
    op(0, 1, 0, 8'h05);
    check("ld05", {24'b0, acc}, 32'h05);
    op(0, 0, 1, 8'h83);
    check("add83", {24'b0, acc}, 32'h02);
    op(0, 0, 1, 8'h84);
    check("add84", {24'b0, acc}, 32'h82);
    check("add84_ovf", {31'b0, ovf}, 32'h0);

    // 3. overflow saturation, sticky flag, clear
    op(0, 1, 0, 8'h64);
    op(0, 0, 1, 8'h32);
    check("sat_acc", {24'b0, acc}, 32'h7F);
    check("sat_ovf", {31'b0, ovf}, 32'h1);
    op(0, 0, 1, 8'h81);
    check("sticky_acc", {24'b0, acc}, 32'h7E);
    check("sticky_ovf", {31'b0, ovf}, 32'h1);
    op(1, 0, 0, 8'h00);
    check("clr_acc", {24'b0, acc}, 32'h00);
    check("clr_ovf", {31'b0, ovf}, 32'h0);

    // 4. zero results and -0 normalisation
    op(0, 1, 0, 8'h03);
    op(0, 0, 1, 8'h83);
    check("cancel_acc",  {24'b0, acc}, 32'h00);
    check("cancel_zero", {31'b0, zero}, 32'h1);
    op(0, 1, 0, 8'h80);
    check("ld_negzero", {24'b0, acc}, 32'h00);
    check("ld_negzero_z", {31'b0, zero}, 32'h1);

    // 5. strobe priority
    op(0, 1, 0, 8'h05);
    op(1, 1, 1, 8'h11);
    check("prio_clr", {24'b0, acc}, 32'h00);
    op(0, 1, 0, 8'h05);
    op(0, 1, 1, 8'h11);
    check("prio_load", {24'b0, acc}, 32'h11);

    // 6. build acc=9A with ovf=1, then check one full scan and the wrap
    op(0, 1, 0, 8'hFF);
    op(0, 0, 1, 8'h81);
    check("neg_sat_acc", {24'b0, acc}, 32'hFF);
    check("neg_sat_ovf", {31'b0, ovf}, 32'h1);
    op(0, 0, 1, 8'h65);
    check("acc9a", {24'b0, acc}, 32'h9A);
    check("acc9a_ovf", {31'b0, ovf}, 32'h1);
    check("acc9a_zero", {31'b0, zero}, 32'h0);
    wait_an(4'b1000, "sync_d3");
    wait_an(4'b0001, "sync_d0");
    for (int i = 0; i < 16; i++) begin
      check($sformatf("scan_an%0d", i), {28'b0, an}, 32'(4'b0001 << (i / 4)));
      check($sformatf("scan_sseg%0d", i), {24'b0, sseg}, {24'b0, scan_sseg(i / 4)});
      @(negedge clk);
    end
    check("wrap_an", {28'b0, an}, 32'h1);
    check("wrap_sseg", {24'b0, sseg}, 32'hF7);

    // reset mid-scan: immediate effect, coincident strobe ignored, scan restarts
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    din = 8'h05; add_stb = 1'b1;
    #1;
    check("mid_rst_an",   {28'b0, an}, 32'h0);
    check("mid_rst_sseg", {24'b0, sseg}, 32'h00);
    check("mid_rst_acc",  {24'b0, acc}, 32'h00);
    check("mid_rst_ovf",  {31'b0, ovf}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_strobe_ign", {24'b0, acc}, 32'h00);
    add_stb = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("restart_an",   {28'b0, an}, 32'h1);
    check("restart_sseg", {24'b0, sseg}, 32'h7E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
